// File: rtl/read_address_gen.sv
// read_address_gen
//   Walks a circular line buffer of DEPTH entries. Each window produces WIN
//   consecutive read addresses. Each new window starts STRIDE entries after
//   the previous one, and all addresses wrap modulo DEPTH. A job runs for a
//   programmable number of windows.
//
// Optional feature: define READ_ADDR_GEN_PERF_EN to add the stall_cycles_o
//   output. It is a saturating count of RUN cycles that have can_count_i low.
//
// Ports
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          begin a job (only honoured in IDLE)
//   can_count_i      advance enable from the buffer write side
//   clear_i          synchronous abort back to IDLE
//   base_addr_i      first window start address (must be < DEPTH)
//   num_windows_i    windows in the job (0 = empty job, completes at once)
//   rd_addr_o        current read address, held when rd_valid_o is low
//   rd_valid_o       rd_addr_o valid this cycle
//   load_registers_o datapath load strobe, same as rd_valid_o
//   window_done_o    pulse on the last address of each window
//   busy_o           high in RUN and DONE
//   stall_cycles_o   (READ_ADDR_GEN_PERF_EN only) stall cycle counter
//   done_o           one-cycle pulse at job completion
module read_address_gen #(
  parameter  int DEPTH  = 16,
  parameter  int WIN    = 4,
  parameter  int STRIDE = 1,
  parameter  int CNT_W  = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              can_count_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_windows_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic              load_registers_o,
  output logic              window_done_o,
  output logic              busy_o,
`ifdef READ_ADDR_GEN_PERF_EN
  output logic [15:0]       stall_cycles_o,
`endif
  output logic              done_o
);

  localparam int              KW       = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [KW-1:0]   K_LAST   = KW'(WIN - 1);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] STRIDE_X = (ADDR_W + 1)'(STRIDE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  winStart_q, winStart_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CNT_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   numWindows_q, numWindows_d;
  logic [ADDR_W-1:0]  addrHold_q, addrHold_d;

  logic               gateOut;
  logic               fire;
  logic               accept;
  logic               lastInWindow;
  logic               lastWindow;
  logic [ADDR_W-1:0]  curAddr;
  logic [ADDR_W-1:0]  nextWinStart;

  // Modular add of two operands that are each at most DEPTH. The sum is
  // formed one bit wider, so one conditional subtract of DEPTH is enough
  // to bring it back into range.
  function automatic logic [ADDR_W-1:0] wrapAdd(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W:0]   b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + b;
    if (sum >= DEPTH_X) begin
      sum = sum - DEPTH_X;
    end
    return sum[ADDR_W-1:0];
  endfunction

  // Both reset and clear force every output to zero in the cycle they are
  // asserted, so they share one gate.
  assign gateOut      = rst_i | clear_i;
  assign fire         = (state_q == RUN) & can_count_i & ~gateOut;
  assign accept       = (state_q == IDLE) & start_i & ~clear_i;
  assign lastInWindow = (k_q == K_LAST);
  assign lastWindow   = (w_q == numWindows_q - CNT_W'(1));
  assign curAddr      = wrapAdd(winStart_q, (ADDR_W + 1)'(k_q));
  assign nextWinStart = wrapAdd(winStart_q, STRIDE_X);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Clear always wins. An empty job goes straight to DONE
  // so that it still produces a done pulse.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = (num_windows_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire && lastInWindow && lastWindow) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers: window start, position in the window, window count,
  // latched job length, and the last emitted address. The last emitted
  // address keeps rd_addr_o steady while no address is being issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      winStart_q   <= '0;
      k_q          <= '0;
      w_q          <= '0;
      numWindows_q <= '0;
      addrHold_q   <= '0;
    end else begin
      winStart_q   <= winStart_d;
      k_q          <= k_d;
      w_q          <= w_d;
      numWindows_q <= numWindows_d;
      addrHold_q   <= addrHold_d;
    end
  end

  // Datapath next values. When the last address of a window is issued, the
  // block steps to the next window start.
  always_comb begin
    winStart_d   = winStart_q;
    k_d          = k_q;
    w_d          = w_q;
    numWindows_d = numWindows_q;
    addrHold_d   = addrHold_q;
    if (clear_i) begin
      winStart_d   = '0;
      k_d          = '0;
      w_d          = '0;
      numWindows_d = '0;
      addrHold_d   = '0;
    end else if (accept) begin
      winStart_d   = base_addr_i;
      numWindows_d = num_windows_i;
      k_d          = '0;
      w_d          = '0;
    end else if (fire) begin
      addrHold_d = curAddr;
      if (lastInWindow) begin
        k_d        = '0;
        w_d        = w_q + CNT_W'(1);
        winStart_d = nextWinStart;
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  // Outputs. The address is combinational from the registers, so it appears
  // in the same cycle as can_count_i.
  always_comb begin
    rd_valid_o       = fire;
    load_registers_o = fire;
    window_done_o    = fire & lastInWindow;
    busy_o           = ~gateOut & ((state_q == RUN) | (state_q == DONE));
    done_o           = ~gateOut & (state_q == DONE);
    if (gateOut) begin
      rd_addr_o = '0;
    end else if (fire) begin
      rd_addr_o = curAddr;
    end else begin
      rd_addr_o = addrHold_q;
    end
  end

`ifdef READ_ADDR_GEN_PERF_EN
  logic [15:0] stallCycles_q, stallCycles_d;

  // Stall counter. Clear leaves it untouched, so the count survives an
  // aborted job. An accepted start restarts it from zero.
  always_comb begin
    stallCycles_d = stallCycles_q;
    if (accept) begin
      stallCycles_d = '0;
    end else if ((state_q == RUN) && !can_count_i && (stallCycles_q != 16'hFFFF)) begin
      stallCycles_d = stallCycles_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCycles_q <= '0;
    end else begin
      stallCycles_q <= stallCycles_d;
    end
  end

  assign stall_cycles_o = stallCycles_q;
`endif

endmodule

// File: tb/tb_read_address_gen.sv
// Testbench for read_address_gen. Two instances share all inputs: one uses
// STRIDE=1 and the other STRIDE=4. Both use DEPTH=16 and WIN=4. The expected
// values come from a job-level model: the n-th address of a job is computed
// directly as (base + (n / WIN) * STRIDE + n % WIN) mod DEPTH.
module tb_read_address_gen;

  localparam int DEPTH  = 16;
  localparam int WIN    = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              canCount;
  logic              clear;
  logic [ADDR_W-1:0] baseAddr;
  logic [CNT_W-1:0]  numWindows;

  logic [1:0][ADDR_W-1:0] rdAddr;
  logic [1:0]             rdValid;
  logic [1:0]             loadRegs;
  logic [1:0]             winDone;
  logic [1:0]             busy;
  logic [1:0]             done;
`ifdef READ_ADDR_GEN_PERF_EN
  logic [1:0][15:0]       stallCycles;
`endif

  read_address_gen #(.DEPTH(DEPTH), .WIN(WIN), .STRIDE(1), .CNT_W(CNT_W)) dutA (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .can_count_i     (canCount),
    .clear_i         (clear),
    .base_addr_i     (baseAddr),
    .num_windows_i   (numWindows),
    .rd_addr_o       (rdAddr[0]),
    .rd_valid_o      (rdValid[0]),
    .load_registers_o(loadRegs[0]),
    .window_done_o   (winDone[0]),
    .busy_o          (busy[0]),
`ifdef READ_ADDR_GEN_PERF_EN
    .stall_cycles_o  (stallCycles[0]),
`endif
    .done_o          (done[0])
  );

  read_address_gen #(.DEPTH(DEPTH), .WIN(WIN), .STRIDE(4), .CNT_W(CNT_W)) dutB (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .can_count_i     (canCount),
    .clear_i         (clear),
    .base_addr_i     (baseAddr),
    .num_windows_i   (numWindows),
    .rd_addr_o       (rdAddr[1]),
    .rd_valid_o      (rdValid[1]),
    .load_registers_o(loadRegs[1]),
    .window_done_o   (winDone[1]),
    .busy_o          (busy[1]),
`ifdef READ_ADDR_GEN_PERF_EN
    .stall_cycles_o  (stallCycles[1]),
`endif
    .done_o          (done[1])
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Job-level model state
  int strides[2] = '{1, 4};
  bit mRun   = 1'b0;
  bit mDone  = 1'b0;
  int mBase  = 0;
  int mNum   = 0;
  int mPos   = 0;
  int mHold[2] = '{0, 0};
  int mStall = 0;

  // n-th address of the current job for instance d
  function automatic int addrOf(input int d, input int n);
    return (mBase + (n / WIN) * strides[d] + (n % WIN)) % DEPTH;
  endfunction

  // Single checking point. It counts the comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, then
  // step the model across the coming rising edge.
  task automatic applyStimulus(input bit r, input bit cl, input bit st, input bit cc,
                               input int base, input int num);
    bit gate;
    bit fire;
    int expAddr;
    @(negedge clk);
    rst        = r;
    clear      = cl;
    start      = st;
    canCount   = cc;
    baseAddr   = ADDR_W'(base);
    numWindows = CNT_W'(num);
    #1;
    gate = r | cl;
    fire = mRun & cc & ~gate;
    for (int d = 0; d < 2; d++) begin
      expAddr = gate ? 0 : (fire ? addrOf(d, mPos) : mHold[d]);
      if (!cl) begin
        checkOutput($sformatf("c%0d d%0d rd_addr", cycle, d), int'(rdAddr[d]), expAddr);
      end
      checkOutput($sformatf("c%0d d%0d rd_valid", cycle, d), int'(rdValid[d]), int'(fire));
      checkOutput($sformatf("c%0d d%0d load_registers", cycle, d), int'(loadRegs[d]), int'(fire));
      checkOutput($sformatf("c%0d d%0d window_done", cycle, d), int'(winDone[d]),
                  int'(fire && (mPos % WIN == WIN - 1)));
      checkOutput($sformatf("c%0d d%0d busy", cycle, d), int'(busy[d]),
                  int'(!gate && (mRun || mDone)));
      checkOutput($sformatf("c%0d d%0d done", cycle, d), int'(done[d]), int'(!gate && mDone));
`ifdef READ_ADDR_GEN_PERF_EN
      checkOutput($sformatf("c%0d d%0d stall_cycles", cycle, d), int'(stallCycles[d]), mStall);
`endif
    end

    if (r) begin
      mRun = 0; mDone = 0; mHold = '{0, 0}; mStall = 0; mPos = 0;
    end else begin
      if (mRun && !cc && mStall < 65535) mStall++;
      if (cl) begin
        mRun = 0; mDone = 0; mHold = '{0, 0}; mPos = 0;
      end else if (mDone) begin
        mDone = 0;
      end else if (mRun) begin
        if (fire) begin
          for (int d = 0; d < 2; d++) mHold[d] = addrOf(d, mPos);
          mPos++;
          if (mPos == mNum * WIN) begin
            mRun = 0;
            mDone = 1;
          end
        end
      end else if (st) begin
        mStall = 0;
        mBase  = base;
        mNum   = num;
        mPos   = 0;
        if (num == 0) mDone = 1;
        else          mRun  = 1;
      end
    end
    cycle++;
  endtask

  task automatic runCycles(input int n, input bit cc);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, cc, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; canCount = 1'b0; clear = 1'b0;
    baseAddr = '0; numWindows = '0;

    // Reset, then the cycle after reset
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    runCycles(2, 1);

    // Plain job with wrap-around: base 14, two windows
    applyStimulus(0, 0, 1, 1, 14, 2);
    runCycles(11, 1);

    // Same job with a three-cycle stall after the second address
    applyStimulus(0, 0, 1, 1, 14, 2);
    runCycles(2, 1);
    runCycles(3, 0);
    runCycles(8, 1);
    runCycles(2, 1);

    // Empty job
    applyStimulus(0, 0, 1, 1, 3, 0);
    runCycles(3, 1);

    // Clear on the third address, then a fresh job from base 5
    applyStimulus(0, 0, 1, 1, 14, 2);
    runCycles(2, 1);
    applyStimulus(0, 1, 0, 1, 0, 0);
    runCycles(1, 1);
    applyStimulus(0, 0, 1, 1, 5, 1);
    runCycles(6, 1);

    // Start while busy is ignored
    applyStimulus(0, 0, 1, 1, 14, 2);
    runCycles(3, 1);
    applyStimulus(0, 0, 1, 1, 9, 3);
    runCycles(8, 1);

    // Reset in the middle of a job
    applyStimulus(0, 0, 1, 1, 2, 3);
    runCycles(3, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    runCycles(2, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(299, 0) == 0),
                    ($urandom_range(79, 0) == 0),
                    ($urandom_range(5, 0) == 0),
                    ($urandom_range(3, 0) != 0),
                    int'($urandom_range(DEPTH - 1, 0)),
                    int'($urandom_range(4, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_address_gen.md
Name: read_address_gen

Overview:
Parametrised successor to the single-bit read-address controller. Walks a circular line buffer of DEPTH entries and emits, per window, WIN consecutive read addresses. Successive windows advance by STRIDE, wrapping modulo DEPTH, for a programmable number of windows. Sits between the buffer write side (which supplies can_count) and the compute datapath (which consumes rd_addr, rd_valid and load_registers).

Parameters:
DEPTH, 16, number of buffer entries; ADDR_W = $clog2(DEPTH) is a localparam
WIN, 4, addresses emitted per window (1..DEPTH)
STRIDE, 1, window-start advance per window (1..DEPTH)
CNT_W, 8, width of the window-count input

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
can_count  in  1  buffer holds valid data and downstream can accept; advance enable
clear  in  1  synchronous abort; returns the block to IDLE
base_addr  in  ADDR_W  first window start address; latched on accepted start; must be < DEPTH
num_windows  in  CNT_W  windows in the job; latched on accepted start
rd_addr  out  ADDR_W  current read address
rd_valid  out  1  rd_addr valid this cycle
load_registers  out  1  datapath register load strobe; equals rd_valid
window_done  out  1  pulse on the last address of each window
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE. Reset → IDLE.
- Registers: win_start, k (0..WIN-1), w (window count), num_windows.
- rst clears all registers to 0. Outputs during reset and the cycle after: rd_addr=0, rd_valid=0, load_registers=0, window_done=0, busy=0, done=0.
- IDLE → RUN: on start=1 with num_windows≠0. Latch win_start=base_addr and num_windows; set k=0, w=0.
- IDLE → DONE: on start=1 with num_windows=0. done pulses next cycle; no address is emitted.
- Define fire = (state==RUN) & can_count & ~clear.
- Outputs:
  - rd_valid = load_registers = fire.
  - rd_addr = (win_start + k) mod DEPTH. Compute at ADDR_W+1 bits and subtract DEPTH if the sum ≥ DEPTH. Combinational from registers: 0-cycle latency from can_count.
  - rd_addr is held at its last value (not forced to 0) when rd_valid=0.
- can_count=0 in RUN: stall. All registers are held and no output pulses.
- On fire with k<WIN-1: k++.
- On fire with k==WIN-1:
  - window_done=1 (combinational, same cycle).
  - k=0, w++, win_start = (win_start+STRIDE) mod DEPTH.
  - If w==num_windows-1, next state is DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then → IDLE.
- start while busy is ignored; latched values are unchanged.
- clear=1 in any state → IDLE next cycle. Registers reset as for rst, except the perf counter.
  - clear has priority over fire and start in the same cycle; outputs are gated to 0 that cycle.
- rst has priority over everything.
- Wrap-around: addresses and window starts wrap DEPTH-1 → 0 with no bubble.

Optional Feature:
Macro: READ_ADDR_GEN_PERF_EN.
- Defined: adds output stall_cycles [15:0].
  - Counts cycles with state==RUN & can_count==0.
  - Saturates at 16'hFFFF.
  - Cleared by rst and by an accepted start; not cleared by clear.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. DEPTH=16, WIN=4, STRIDE=1, base=14, num=2, can_count=1 → rd_addr 14,15,0,1,15,0,1,2 on consecutive cycles; window_done on the 4th and 8th; done one cycle after the 8th; busy high for 9 cycles.
2. Same job with can_count low for 3 cycles after the 2nd address → rd_valid=0 and rd_addr held at 15 for 3 cycles; sequence resumes at 0 with no skip or duplicate; PERF_EN stall_cycles=3.
3. start with num=0 → no rd_valid; done=1 one cycle later; back to IDLE.
4. STRIDE=4, WIN=4, base=12, num=2 → 12,13,14,15,0,1,2,3.
5. clear asserted on the 3rd address cycle → rd_valid=0 that cycle; IDLE next cycle with busy=0; a new start with base=5 emits 5 first.
6. start re-asserted with base=9 mid-job → ignored; original sequence completes unchanged. rst mid-job → all outputs 0 next cycle.
